// File: rtl/pgr_fft_wr_switch.sv
// FFT butterfly write switch: re-pairs butterfly results into RAM write beats,
// either passing level-1 beats straight through or interleaving even/odd beat pairs.
module pgr_fft_wr_switch #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  first_level,
  input  logic                  butterfly_vld,
  input  logic [ADDR_WIDTH-1:0] addr_index,
  input  logic [DATA_WIDTH-1:0] butterfly_aout,
  input  logic [DATA_WIDTH-1:0] butterfly_bout,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_wr_valid,
  output logic [DATA_WIDTH-1:0] oa_wr_data,
  output logic [DATA_WIDTH-1:0] ob_wr_data,
  output logic                  o_busy
);

  logic                  phase_q, phase_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_a_q, hold_a_d;
  logic [DATA_WIDTH-1:0] hold_b_q, hold_b_d;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_pass_q, s1_pass_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;

  logic                  p_vld_q, p_vld_d;
  logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
  logic [DATA_WIDTH-1:0] p_a_q, p_a_d;
  logic [DATA_WIDTH-1:0] p_b_q, p_b_d;

  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_a_q, wr_a_d;
  logic [DATA_WIDTH-1:0] wr_b_q, wr_b_d;

  logic even_beat, odd_beat, pass_beat, s1_odd;

  always_comb begin
    // Mode is only sampled on phase-0 beats; an odd beat keeps the pair's mode.
    mode_d    = mode_q;
    if (butterfly_vld && !phase_q) mode_d = first_level;
    pass_beat = butterfly_vld && !phase_q && mode_d;
    even_beat = butterfly_vld && !phase_q && !mode_d;
    odd_beat  = butterfly_vld && phase_q;

    phase_d = phase_q;
    if (even_beat)     phase_d = 1'b1;
    else if (odd_beat) phase_d = 1'b0;

    hold_addr_d = hold_addr_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    if (even_beat) begin
      hold_addr_d = addr_index;
      hold_a_d    = butterfly_aout;
      hold_b_d    = butterfly_bout;
    end

    s1_vld_d  = odd_beat || pass_beat;
    s1_pass_d = pass_beat;
    s1_addr_d = s1_addr_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    if (butterfly_vld) begin
      s1_addr_d = addr_index;
      s1_a_d    = butterfly_aout;
      s1_b_d    = butterfly_bout;
    end

    // Pass-through beats wait one slot here so their latency matches the pair path.
    s1_odd   = s1_vld_q && !s1_pass_q;
    p_vld_d  = s1_vld_q;
    p_addr_d = p_addr_q;
    p_a_d    = p_a_q;
    p_b_d    = p_b_q;
    if (s1_vld_q) begin
      p_addr_d = s1_addr_q;
      p_a_d    = s1_pass_q ? s1_a_q : hold_b_q;
      p_b_d    = s1_b_q;
    end

    wr_valid_d = s1_odd || p_vld_q;
    wr_addr_d  = wr_addr_q;
    wr_a_d     = wr_a_q;
    wr_b_d     = wr_b_q;
    if (s1_odd) begin
      wr_addr_d = hold_addr_q;
      wr_a_d    = hold_a_q;
      wr_b_d    = s1_a_q;
    end else if (p_vld_q) begin
      wr_addr_d = p_addr_q;
      wr_a_d    = p_a_q;
      wr_b_d    = p_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= 1'b0;
      mode_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_pass_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      p_vld_q     <= 1'b0;
      p_addr_q    <= '0;
      p_a_q       <= '0;
      p_b_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_a_q      <= '0;
      wr_b_q      <= '0;
    end else begin
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      hold_addr_q <= hold_addr_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      s1_vld_q    <= s1_vld_d;
      s1_pass_q   <= s1_pass_d;
      s1_addr_q   <= s1_addr_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      p_vld_q     <= p_vld_d;
      p_addr_q    <= p_addr_d;
      p_a_q       <= p_a_d;
      p_b_q       <= p_b_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_a_q      <= wr_a_d;
      wr_b_q      <= wr_b_d;
    end
  end

  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign oa_wr_data = wr_a_q;
  assign ob_wr_data = wr_b_q;
  assign o_busy     = phase_q || s1_vld_q || p_vld_q;

endmodule

// File: tb/tb_pgr_fft_wr_switch.sv
// Directed bench for pgr_fft_wr_switch: pair, pass-through, gap and reset scenarios.
module tb_pgr_fft_wr_switch;

  localparam int AW = 18;
  localparam int DW = 18;

  logic          clk;
  logic          rst_n;
  logic          first_level;
  logic          butterfly_vld;
  logic [AW-1:0] addr_index;
  logic [DW-1:0] butterfly_aout;
  logic [DW-1:0] butterfly_bout;
  logic [AW-1:0] o_wr_addr;
  logic          o_wr_valid;
  logic [DW-1:0] oa_wr_data;
  logic [DW-1:0] ob_wr_data;
  logic          o_busy;

  int n_checks;
  int n_errors;

  pgr_fft_wr_switch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .first_level    (first_level),
    .butterfly_vld  (butterfly_vld),
    .addr_index     (addr_index),
    .butterfly_aout (butterfly_aout),
    .butterfly_bout (butterfly_bout),
    .o_wr_addr      (o_wr_addr),
    .o_wr_valid     (o_wr_valid),
    .oa_wr_data     (oa_wr_data),
    .ob_wr_data     (ob_wr_data),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic fl, input int addr, input int a, input int b);
    butterfly_vld  = 1'b1;
    first_level    = fl;
    addr_index     = AW'(addr);
    butterfly_aout = DW'(a);
    butterfly_bout = DW'(b);
  endtask

  task automatic idle();
    butterfly_vld = 1'b0;
    first_level   = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int addr, input int a, input int b);
    $display("txn %s: valid=%0b addr=%0d oa=%0h ob=%0h", tag, o_wr_valid, o_wr_addr, oa_wr_data, ob_wr_data);
    chk({tag, "_vld"}, 32'(o_wr_valid), 32'd1);
    chk({tag, "_addr"}, 32'(o_wr_addr), 32'(addr));
    chk({tag, "_oa"}, 32'(oa_wr_data), 32'(a));
    chk({tag, "_ob"}, 32'(ob_wr_data), 32'(b));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle();
    addr_index = '0;
    butterfly_aout = '0;
    butterfly_bout = '0;

    // Reset values
    #12;
    chk("rst_vld", 32'(o_wr_valid), 32'd0);
    chk("rst_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_oa", 32'(oa_wr_data), 32'd0);
    chk("rst_ob", 32'(ob_wr_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    #2 rst_n = 1'b1;
    step();

    // Back-to-back pair: (1,2,@4) then (3,5,@5)
    beat(1'b0, 4, 1, 2);
    step();
    beat(1'b0, 5, 3, 5);
    step();
    idle();
    chk("pair_busy", 32'(o_busy), 32'd1);
    chk("pair_novld", 32'(o_wr_valid), 32'd0);
    step();
    chk_wr("pair_w1", 4, 1, 3);
    step();
    chk_wr("pair_w2", 5, 2, 5);
    step();
    chk("pair_end_vld", 32'(o_wr_valid), 32'd0);
    chk("pair_hold_addr", 32'(o_wr_addr), 32'd5);
    chk("pair_hold_ob", 32'(ob_wr_data), 32'd5);
    chk("pair_end_busy", 32'(o_busy), 32'd0);

    // Three pass-through beats, addr 0..2
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, i, 16 + i, 32 + i);
      step();
    end
    idle();
    chk_wr("pt0", 0, 16, 32);
    step();
    chk_wr("pt1", 1, 17, 33);
    step();
    chk_wr("pt2", 2, 18, 34);
    step();
    chk("pt_end_vld", 32'(o_wr_valid), 32'd0);

    // Even beat, 5-cycle gap, odd beat
    beat(1'b0, 8, 'h11, 'h22);
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("gap_busy%0d", i), 32'(o_busy), 32'd1);
      chk($sformatf("gap_novld%0d", i), 32'(o_wr_valid), 32'd0);
    end
    beat(1'b0, 9, 'h33, 'h44);
    step();
    idle();
    chk("gap_odd_novld", 32'(o_wr_valid), 32'd0);
    step();
    chk_wr("gap_w1", 8, 'h11, 'h33);
    step();
    chk_wr("gap_w2", 9, 'h22, 'h44);
    step();
    chk("gap_end_vld", 32'(o_wr_valid), 32'd0);

    // Pair (first_level raised on the odd beat) followed by a pass-through beat
    beat(1'b0, 16, 1, 2);
    step();
    beat(1'b1, 17, 3, 4);
    step();
    beat(1'b1, 18, 5, 6);
    step();
    idle();
    chk_wr("mix_w1", 16, 1, 3);
    step();
    chk_wr("mix_w2", 17, 2, 4);
    step();
    chk_wr("mix_pt", 18, 5, 6);
    step();
    chk("mix_end_vld", 32'(o_wr_valid), 32'd0);

    // Reset after an even beat discards it
    beat(1'b0, 20, 'h55, 'h66);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(o_wr_valid), 32'd0);
    chk("mrst_addr", 32'(o_wr_addr), 32'd0);
    chk("mrst_oa", 32'(oa_wr_data), 32'd0);
    chk("mrst_ob", 32'(ob_wr_data), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_quiet%0d", i), 32'(o_wr_valid), 32'd0);
    end
    beat(1'b0, 24, 7, 8);
    step();
    beat(1'b0, 25, 9, 10);
    step();
    idle();
    step();
    chk_wr("post_w1", 24, 7, 9);
    step();
    chk_wr("post_w2", 25, 8, 10);
    step();
    chk("post_end_vld", 32'(o_wr_valid), 32'd0);
    chk("post_end_busy", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
